// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// Serial loader for the instruction memory: parses a framed, checksummed byte stream,
// writes big-endian words from address 0 and releases the processor reset on success.
module imem_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned TmoW     = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MaxWords = 17'(1 << ADDR_W);
  localparam logic [7:0]  SyncByte = 8'hA5;

  typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StSum, StDone, StErr} state_e;

  state_e            r_state, w_state_nxt;
  logic [7:0]        r_len_hi, w_len_hi_nxt;
  logic [16:0]       r_len, w_len_nxt;
  logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
  logic [23:0]       r_asm, w_asm_nxt;
  logic [7:0]        r_sum, w_sum_nxt;
  logic [TmoW-1:0]   r_tmo, w_tmo_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic [1:0]        r_err_code, w_err_code_nxt;
  logic [ADDR_W:0]   r_word_count, w_word_count_nxt;
  logic              r_busy, r_done, r_err, r_cpu_rstd;

  logic              w_accept;
  logic              w_in_frame;
  logic [16:0]       w_len_rx;
  logic [7:0]        w_sum_add;

  assign in_ready = (r_state != StDone);

  always_comb begin
    w_state_nxt      = r_state;
    w_len_hi_nxt     = r_len_hi;
    w_len_nxt        = r_len;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_asm_nxt        = r_asm;
    w_sum_nxt        = r_sum;
    w_tmo_nxt        = '0;
    w_we_nxt         = 1'b0;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_err_code_nxt   = r_err_code;
    w_word_count_nxt = r_word_count;

    w_accept   = in_valid && in_ready;
    w_in_frame = r_state inside {StLen0, StLen1, StData, StSum};
    w_len_rx   = {1'b0, r_len_hi, in_data};
    w_sum_add  = r_sum + in_data;

    if (w_in_frame && !w_accept && (32'(r_tmo) != TIMEOUT)) begin
      w_tmo_nxt = r_tmo + TmoW'(1);
    end

    case (r_state)
      StIdle, StErr: begin
        if (w_accept && (in_data == SyncByte)) begin
          w_state_nxt    = StLen0;
          w_err_code_nxt = 2'd0;
        end
      end
      StLen0: begin
        if (w_accept) begin
          w_len_hi_nxt = in_data;
          w_state_nxt  = StLen1;
        end
      end
      StLen1: begin
        if (w_accept) begin
          if ((w_len_rx == 17'd0) || (w_len_rx > MaxWords)) begin
            w_state_nxt    = StErr;
            w_err_code_nxt = 2'd1;
          end else begin
            w_state_nxt      = StData;
            w_len_nxt        = w_len_rx;
            w_word_count_nxt = '0;
            w_byte_cnt_nxt   = 2'd0;
            w_sum_nxt        = 8'd0;
          end
        end
      end
      StData: begin
        if (w_accept) begin
          w_sum_nxt      = w_sum_add;
          w_asm_nxt      = {r_asm[15:0], in_data};
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_we_nxt         = 1'b1;
            w_addr_nxt       = r_word_count[ADDR_W-1:0];
            w_wdata_nxt      = {r_asm, in_data};
            w_word_count_nxt = r_word_count + 1'b1;
            if ((17'(r_word_count) + 17'd1) == r_len) begin
              w_state_nxt = StSum;
            end
          end
        end
      end
      StSum: begin
        if (w_accept) begin
          if (w_sum_add == 8'd0) begin
            w_state_nxt = StDone;
          end else begin
            w_state_nxt    = StErr;
            w_err_code_nxt = 2'd2;
          end
        end
      end
      StDone: ;
      default: w_state_nxt = StIdle;
    endcase

    // Idle-cycle limit reached inside a frame: abort regardless of the decoded path.
    if (w_in_frame && !w_accept && ((32'(r_tmo) + 32'd1) >= TIMEOUT)) begin
      w_state_nxt    = StErr;
      w_err_code_nxt = 2'd3;
      w_tmo_nxt      = '0;
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_state      <= StIdle;
      r_len_hi     <= '0;
      r_len        <= '0;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
      r_sum        <= '0;
      r_tmo        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err_code   <= '0;
      r_word_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cpu_rstd   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len_hi     <= w_len_hi_nxt;
      r_len        <= w_len_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_asm        <= w_asm_nxt;
      r_sum        <= w_sum_nxt;
      r_tmo        <= w_tmo_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_err_code   <= w_err_code_nxt;
      r_word_count <= w_word_count_nxt;
      r_busy       <= w_state_nxt inside {StLen0, StLen1, StData, StSum};
      r_done       <= (w_state_nxt == StDone);
      r_err        <= (w_state_nxt == StErr);
      r_cpu_rstd   <= (w_state_nxt == StDone);
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_rstd   = r_cpu_rstd;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Bench for imem_loader: drives framed byte streams and scoreboards every instruction-memory
// write against words computed from the frames it sends.
module tb_imem_loader;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 1000;

  logic          clk = 1'b0;
  logic          rstd;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rstd;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rstd       (rstd),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rstd   (cpu_rstd),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int unsigned      n_chk;
  int unsigned      n_pass;
  logic [AW+31:0]   sb[$];
  logic [31:0]      fw[$];
  logic [7:0]       run_sum;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Write monitor: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    logic [AW+31:0] e;
    if (rstd === 1'b1 && imem_we === 1'b1) begin
      chk("we_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("we_addr", 64'(imem_addr), 64'(e[AW+31:32]));
        chk("we_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic put(input logic [7:0] b, input bit gaps);
    int g;
    g = gaps ? $urandom_range(0, 3) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_words(input bit gaps, input int limit);
    int sent;
    sent = 0;
    for (int i = 0; i < fw.size(); i++) begin
      for (int j = 3; j >= 0; j--) begin
        logic [7:0] b;
        if (sent < limit) begin
          b = fw[i][8*j +: 8];
          run_sum = run_sum + b;
          if (j == 0) sb.push_back({AW'(i), fw[i]});
          put(b, gaps);
          sent++;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_we"},    64'(imem_we), 64'd0);
    chk({tag, "_addr"},  64'(imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_cpu"},   64'(cpu_rstd), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_err"},   64'(err), 64'd0);
    chk({tag, "_code"},  64'(err_code), 64'd0);
    chk({tag, "_wc"},    64'(word_count), 64'd0);
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rstd     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rstd = 1'b1;

    // Zero length
    put(8'hA5, 0);
    chk("sync_busy", 64'(busy), 64'd1);
    put(8'h00, 0);
    put(8'h00, 0);
    chk("len0_err", 64'(err), 64'd1);
    chk("len0_code", 64'(err_code), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);

    // Length 257 exceeds 2^ADDR_W
    put(8'hA5, 0);
    chk("resync_err", 64'(err), 64'd0);
    chk("resync_code", 64'(err_code), 64'd0);
    put(8'h01, 0);
    put(8'h01, 0);
    chk("len257_err", 64'(err), 64'd1);
    chk("len257_code", 64'(err_code), 64'd1);

    // Length 256 is accepted; stall after two data bytes
    put(8'hA5, 0);
    put(8'h01, 0);
    put(8'h00, 0);
    chk("len256_busy", 64'(busy), 64'd1);
    chk("len256_err", 64'(err), 64'd0);
    put(8'h12, 0);
    put(8'h34, 0);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    chk("tmo_early", 64'(err), 64'd0);
    @(posedge clk); #1;
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_code", 64'(err_code), 64'd3);
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_nowrite", 64'(sb.size()), 64'd0);

    // Checksum off by one
    fw = '{32'h8C010004, 32'h00000000};
    run_sum = 8'd0;
    put(8'hA5, 0);
    put(8'h00, 0);
    put(8'h02, 0);
    send_words(0, 8);
    put(8'(8'd1 - run_sum), 0);
    chk("bad_csum_err", 64'(err), 64'd1);
    chk("bad_csum_code", 64'(err_code), 64'd2);
    chk("bad_csum_cpu", 64'(cpu_rstd), 64'd0);
    chk("bad_csum_wc", 64'(word_count), 64'd2);
    chk("bad_csum_drain", 64'(sb.size()), 64'd0);

    // Same frame, correct checksum
    run_sum = 8'd0;
    put(8'hA5, 0);
    chk("good_sync_err", 64'(err), 64'd0);
    chk("good_sync_code", 64'(err_code), 64'd0);
    put(8'h00, 0);
    put(8'h02, 0);
    send_words(0, 8);
    chk("good_cpu_held", 64'(cpu_rstd), 64'd0);
    chk("good_csum_val", 64'(8'(8'd0 - run_sum)), 64'h6F);
    put(8'(8'd0 - run_sum), 0);
    chk("good_done", 64'(done), 64'd1);
    chk("good_cpu", 64'(cpu_rstd), 64'd1);
    chk("good_ready", 64'(in_ready), 64'd0);
    chk("good_busy", 64'(busy), 64'd0);
    chk("good_err", 64'(err), 64'd0);
    chk("good_wc", 64'(word_count), 64'd2);
    chk("good_drain", 64'(sb.size()), 64'd0);

    // DONE is terminal
    put(8'hA5, 0);
    chk("term_done", 64'(done), 64'd1);
    chk("term_busy", 64'(busy), 64'd0);

    #2 rstd = 1'b0;
    #1 check_reset_outputs("rst_done");
    @(posedge clk); #1 rstd = 1'b1;

    // Abort mid-DATA with reset after one word has been written
    fw = '{32'hDEADBEEF, 32'h01234567};
    run_sum = 8'd0;
    put(8'hA5, 0);
    put(8'h00, 0);
    put(8'h02, 0);
    send_words(0, 6);
    chk("mid_wc", 64'(word_count), 64'd1);
    #2 rstd = 1'b0;
    #1 check_reset_outputs("rst_mid");
    chk("mid_drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1 rstd = 1'b1;

    // Garbage then a 1-word frame with random valid gaps
    fw = '{32'hCAFEF00D};
    run_sum = 8'd0;
    put(8'h00, 1);
    put(8'hFF, 1);
    put(8'h13, 1);
    chk("garbage_busy", 64'(busy), 64'd0);
    chk("garbage_err", 64'(err), 64'd0);
    put(8'hA5, 1);
    put(8'h00, 1);
    put(8'h01, 1);
    send_words(1, 4);
    put(8'(8'd0 - run_sum), 1);
    chk("rand_done", 64'(done), 64'd1);
    chk("rand_cpu", 64'(cpu_rstd), 64'd1);
    chk("rand_wc", 64'(word_count), 64'd1);
    repeat (2) @(posedge clk);
    #1 chk("rand_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
